inv_mix_columns_seq: RTL and testbench

//  Sequential AES InvMixColumns unit: the decrypt-side counterpart of mix_columns.

---
 rtl/aes_pkg.sv | 37 +++
 rtl/inv_mix_word.sv | 25 ++
 rtl/inv_mix_columns_seq.sv | 81 ++++++++
 tb/tb_inv_mix_columns_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) helpers and types for the vector-unit MixColumns/InvMixColumns blocks.
// A column is four bytes with byte0 (the first state row) in the most significant position.
package aes_pkg;

   localparam logic [7:0] AES_POLY = 8'h1B;

   typedef logic [7:0] byte_t;
   typedef byte_t [3:0] column_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Multiply by x modulo x^8+x^4+x^3+x+1
   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

   function automatic byte_t gmul09(input byte_t b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic byte_t gmul0b(input byte_t b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic byte_t gmul0d(input byte_t b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic byte_t gmul0e(input byte_t b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

endpackage

// File: rtl/inv_mix_word.sv
// Combinational InvMixColumns of a single AES column.
// Index 3 of column_t is byte0 (bits [31:24]), so the matrix rows map onto descending indices.
module inv_mix_word
   import aes_pkg::*;
(
   input  column_t col_in,
   output column_t col_out
);

   byte_t b0, b1, b2, b3;

   assign b0 = col_in[3];
   assign b1 = col_in[2];
   assign b2 = col_in[1];
   assign b3 = col_in[0];

   always_comb begin
      col_out    = '0;
      col_out[3] = gmul0e(b0) ^ gmul0b(b1) ^ gmul0d(b2) ^ gmul09(b3);
      col_out[2] = gmul09(b0) ^ gmul0e(b1) ^ gmul0b(b2) ^ gmul0d(b3);
      col_out[1] = gmul0d(b0) ^ gmul09(b1) ^ gmul0e(b2) ^ gmul0b(b3);
      col_out[0] = gmul0b(b0) ^ gmul0d(b1) ^ gmul09(b2) ^ gmul0e(b3);
   end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns: one column per clock through a single shared inv_mix_word,
// with valid/ready handshakes on both sides of the vector execute stage.
module inv_mix_columns_seq
   import aes_pkg::*;
#(
   parameter int regSize = 32,
   parameter int vecSize = 4
)
(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [vecSize-1:0][regSize-1:0]  vect,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [vecSize-1:0][regSize-1:0]  new_vect
);

   if (regSize != 32) begin : g_bad_reg_size
      $error("inv_mix_columns_seq: regSize must be 32 (one AES column)");
   end
   if (vecSize < 1) begin : g_bad_vec_size
      $error("inv_mix_columns_seq: vecSize must be at least 1");
   end

   localparam int COL_W = (vecSize > 1) ? $clog2(vecSize) : 1;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(vecSize - 1);

   state_t                           state;
   logic [COL_W-1:0]                 col;
   logic [vecSize-1:0][regSize-1:0]  buffer;
   column_t                          word_in;
   column_t                          word_out;

   assign word_in = buffer[col];

   inv_mix_word u_word (
      .col_in  (word_in),
      .col_out (word_out)
   );

   // vect is only sampled on an IDLE accept, so idle-time X never reaches buffer
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         col    <= '0;
         buffer <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  buffer <= vect;
                  col    <= '0;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               buffer[col] <= word_out;
               if (col == LAST_COL) begin
                  col   <= '0;
                  state <= DONE;
               end else begin
                  col <= col + COL_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign new_vect  = buffer;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq: vector table plus backpressure, abort and back-to-back
// sequences; round-trip vectors are built with an independent forward MixColumns model.
module tb_inv_mix_columns_seq;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [3:0][31:0]  vect;
   logic              out_valid;
   logic              out_ready;
   logic [3:0][31:0]  new_vect;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [127:0] vin;
      logic [127:0] vexp;
   } vec_rec_t;

   vec_rec_t tbl [4];

   inv_mix_columns_seq #(.regSize(32), .vecSize(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .vect      (vect),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .new_vect  (new_vect)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] lanes(input logic [31:0] l0, input logic [31:0] l1,
                                          input logic [31:0] l2, input logic [31:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   // Forward MixColumns model, used only to build round-trip stimulus
   function automatic logic [7:0] tb_x2(input logic [7:0] b);
      return b[7] ? ({b[6:0], 1'b0} ^ 8'h1B) : {b[6:0], 1'b0};
   endfunction

   function automatic logic [31:0] tb_mix_col(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3, r0, r1, r2, r3;
      a0 = w[31:24];
      a1 = w[23:16];
      a2 = w[15:8];
      a3 = w[7:0];
      r0 = tb_x2(a0) ^ tb_x2(a1) ^ a1 ^ a2 ^ a3;
      r1 = a0 ^ tb_x2(a1) ^ tb_x2(a2) ^ a2 ^ a3;
      r2 = a0 ^ a1 ^ tb_x2(a2) ^ tb_x2(a3) ^ a3;
      r3 = tb_x2(a0) ^ a0 ^ a1 ^ a2 ^ tb_x2(a3);
      return {r0, r1, r2, r3};
   endfunction

   function automatic logic [127:0] tb_mix_vec(input logic [127:0] v);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) r[i*32 +: 32] = tb_mix_col(v[i*32 +: 32]);
      return r;
   endfunction

   task automatic checkOutput(input string what, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h, wanted %h", what, act, exp);
      end
   endtask

   // Waits (bounded) for in_ready, then presents vin across one accept edge
   task automatic applyStimulus(input string what, input logic [127:0] vin);
      int waited;
      waited = 0;
      while (!in_ready && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("[TB] FAIL %s accept timeout: in_ready got 0, wanted 1", what);
      end
      vect     = vin;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      vect     = {4{32'hDEADBEEF}};
   endtask

   task automatic waitResult(input string what, input logic [127:0] vexp);
      int lat;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput({what, " latency"}, 128'(lat), 128'd4);
      checkOutput({what, " data"}, new_vect, vexp);
   endtask

   task automatic runVector(input string what, input logic [127:0] vin, input logic [127:0] vexp);
      out_ready = 1'b1;
      applyStimulus(what, vin);
      waitResult(what, vexp);
      @(posedge clk); #1;
      checkOutput({what, " release"}, {126'd0, out_valid, in_ready}, 128'b01);
   endtask

   logic [127:0] known_in, known_out, other_in, other_out, orig1, orig2, mixed1, mixed2;

   initial begin
      known_in  = lanes(32'h591CEEA1, 32'hC28636D1, 32'hCADDAF02, 32'h4A27DCA2);
      known_out = lanes(32'h637BC0D2, 32'h7B76D27C, 32'h76757CC5, 32'h7563C5C0);
      other_in  = {4{32'h8E4DA1BC}};
      other_out = {4{32'hDB135345}};
      tbl[0] = '{vin: known_in,            vexp: known_out};
      tbl[1] = '{vin: other_in,            vexp: other_out};
      tbl[2] = '{vin: {4{32'h01010101}},   vexp: {4{32'h01010101}}};
      tbl[3] = '{vin: 128'd0,              vexp: 128'd0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      vect      = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset out_valid", {127'd0, out_valid}, 128'd0);
      checkOutput("reset in_ready", {127'd0, in_ready}, 128'd1);
      checkOutput("reset new_vect", new_vect, 128'd0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         runVector($sformatf("vec%0d", i), tbl[i].vin, tbl[i].vexp);
      end

      // Backpressure: result held while a competing input is offered
      out_ready = 1'b0;
      applyStimulus("bp", known_in);
      waitResult("bp", known_out);
      vect     = other_in;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("bp hold%0d data", i), new_vect, known_out);
         checkOutput($sformatf("bp hold%0d flags", i), {126'd0, out_valid, in_ready}, 128'b10);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp consume", {126'd0, out_valid, in_ready}, 128'b01);
      @(posedge clk); #1;
      in_valid = 1'b0;
      vect     = {4{32'hDEADBEEF}};
      checkOutput("bp second accept", {127'd0, in_ready}, 128'd0);
      waitResult("bp second", other_out);
      @(posedge clk); #1;

      // Abort in the middle of BUSY (col == 2)
      applyStimulus("abort", other_in);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("abort flags", {126'd0, out_valid, in_ready}, 128'b01);
      checkOutput("abort new_vect", new_vect, 128'd0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("abort idle%0d", i), {127'd0, out_valid}, 128'd0);
      end
      runVector("after abort", known_in, known_out);

      // Back-to-back round trip with in_valid held high
      orig1  = known_out;
      orig2  = lanes(32'h00112233, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h80402010);
      mixed1 = tb_mix_vec(orig1);
      mixed2 = tb_mix_vec(orig2);
      out_ready = 1'b1;
      vect      = mixed1;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      vect = mixed2;
      checkOutput("b2b first accept", {127'd0, in_ready}, 128'd0);
      waitResult("b2b first", orig1);
      @(posedge clk); #1;
      checkOutput("b2b handshake", {126'd0, out_valid, in_ready}, 128'b01);
      @(posedge clk); #1;
      checkOutput("b2b second accept", {127'd0, in_ready}, 128'd0);
      in_valid = 1'b0;
      vect     = {4{32'hDEADBEEF}};
      waitResult("b2b second", orig2);
      @(posedge clk); #1;
      checkOutput("b2b release", {126'd0, out_valid, in_ready}, 128'b01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
